mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 145 ++++++++++++++
 tb/tb_mul_div_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit -- multi-cycle HI/LO multiply/divide unit for a MIPS-style pipeline.
//
// An accepted MULT/MULTU/DIV/DIVU computes its 64-bit result immediately into an
// internal result register. The unit then holds Busy high for MULT_CYCLES or
// DIV_CYCLES cycles before the result is committed to HI/LO. MTHI/MTLO write HI/LO
// directly when the unit is idle.
//
// Ports:
//   clk    in   1   clock, all state updates on posedge
//   reset  in   1   synchronous active-high reset
//   Start  in   1   issue strobe, qualified by MDOp
//   MDOp   in   3   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
//   A      in  32   rs operand
//   B      in  32   rt operand
//   Busy   out  1   high while a multiply/divide is in flight (registered)
//   HI     out 32   architectural HI register
//   LO     out 32   architectural LO register
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic        dz_q, dz_d;     // divide by zero: completion leaves HI/LO alone
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // 64-bit product, operands sign- or zero-extended.
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic signed [63:0] ps;
    logic [63:0]        pu;
    ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    pu = {32'd0, a} * {32'd0, b};
    return sgn ? ps : pu;
  endfunction

  // Returns {remainder, quotient}. Operands are widened to 33 bits so that
  // 0x80000000 / -1 yields +2^31, which truncates to 0x80000000 with remainder 0.
  function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic signed [32:0] sa, sb, sq, sr;
    if (b == 32'd0) return 64'd0;
    sa = sgn ? {a[31], a} : {1'b0, a};
    sb = sgn ? {b[31], b} : {1'b0, b};
    sq = sa / sb;
    sr = sa % sb;
    return {sr[31:0], sq[31:0]};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          case (MDOp)
            OP_MULT, OP_MULTU: begin
              res_d   = mul64(A, B, MDOp == OP_MULT);
              dz_d    = 1'b0;
              cnt_d   = 4'(MULT_CYCLES);
              state_d = MUL;
              busy_d  = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              res_d   = div64(A, B, MDOp == OP_DIV);
              dz_d    = (B == 32'd0);
              cnt_d   = 4'(DIV_CYCLES);
              state_d = DIV;
              busy_d  = 1'b1;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      default: begin
        // MUL and DIV only differ in their load value; both count down here and
        // ignore Start, including on the completing edge.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (!dz_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      res_q   <= 64'd0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed scenarios plus randomized traffic, all
// compared against a behavioural model that tracks remaining busy cycles and the
// pending result computed with plain 64-bit arithmetic.
module tb_mul_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [2:0] NONE = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3,
                         DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6;

  logic        clk = 1'b0;
  logic        reset, Start;
  logic [2:0]  MDOp;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;

  mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_left = 0;
  logic        m_dz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;

  function automatic logic [64:0] exp_vec();
    return {m_left > 0, m_hi, m_lo};
  endfunction

  task automatic model_step(input logic r, input logic s, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, ps;
    longint unsigned pu;
    if (r) begin
      m_left = 0; m_dz = 1'b0; m_hi = '0; m_lo = '0; m_rhi = '0; m_rlo = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && !m_dz) begin
        m_hi = m_rhi;
        m_lo = m_rlo;
      end
    end else if (s) begin
      case (op)
        MULT: begin
          ps = longint'(int'(a)) * longint'(int'(b));
          {m_rhi, m_rlo} = ps;
          m_dz = 1'b0; m_left = MC;
        end
        MULTU: begin
          pu = longint'({32'd0, a}) * longint'({32'd0, b});
          {m_rhi, m_rlo} = pu;
          m_dz = 1'b0; m_left = MC;
        end
        DIV: begin
          m_dz = (b == 0);
          if (b != 0) begin
            sa = longint'(int'(a));
            sb = longint'(int'(b));
            m_rlo = 32'(sa / sb);
            m_rhi = 32'(sa % sb);
          end
          m_left = DC;
        end
        DIVU: begin
          m_dz = (b == 0);
          if (b != 0) begin
            m_rlo = a / b;
            m_rhi = a % b;
          end
          m_left = DC;
        end
        MTHI: m_hi = a;
        MTLO: m_lo = a;
        default: ;
      endcase
    end
  endtask

  task automatic tick(input logic r, input logic s, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    reset = r; Start = s; MDOp = op; A = a; B = b;
    @(posedge clk);
    model_step(r, s, op, a, b);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, MULT, 32'd5, 32'd7);
    tick(1'b1, 1'b0, NONE, 32'd0, 32'd0);
    checks++;
    if ({Busy, HI, LO} !== {1'b0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_state: got busy=%b hi=%h lo=%h want 0/00000000/00000000", Busy, HI, LO);
    end
    tick(1'b0, 1'b0, NONE, 32'd0, 32'd0);
    checks++;
    if ({Busy, HI, LO} !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release: got %h want %h", {Busy, HI, LO}, exp_vec());
    end
  endtask

  task automatic test_mult();
    logic [2:0] ops[2] = '{MULT, MULTU};
    logic [31:0] ehi[2] = '{32'hFFFFFFFF, 32'h00000002};
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, 1'b1, ops[k], 32'hFFFFFFFE, 32'd3);
      for (int i = 0; i < MC; i++) begin
        checks++;
        if (Busy !== 1'b1 || {Busy, HI, LO} !== exp_vec()) begin
          errors++;
          $display("FAIL mult_busy op=%0d cyc=%0d: got %h want busy=1 %h", ops[k], i, {Busy, HI, LO}, exp_vec());
        end
        tick(1'b0, 1'b0, NONE, 32'd0, 32'd0);
      end
      checks++;
      if ({Busy, HI, LO} !== {1'b0, ehi[k], 32'hFFFFFFFA}) begin
        errors++;
        $display("FAIL mult_result op=%0d: got busy=%b hi=%h lo=%h want 0/%h/fffffffa", ops[k], Busy, HI, LO, ehi[k]);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops[3] = '{DIV, DIVU, DIV};
    logic [31:0] av[3]  = '{32'hFFFFFFF9, 32'd7, 32'h80000000};
    logic [31:0] bv[3]  = '{32'd2, 32'd2, 32'hFFFFFFFF};
    logic [31:0] elo[3] = '{32'hFFFFFFFD, 32'd3, 32'h80000000};
    logic [31:0] ehi[3] = '{32'hFFFFFFFF, 32'd1, 32'd0};
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b1, ops[k], av[k], bv[k]);
      for (int i = 0; i < DC; i++) begin
        checks++;
        if (Busy !== 1'b1 || {Busy, HI, LO} !== exp_vec()) begin
          errors++;
          $display("FAIL div_busy case=%0d cyc=%0d: got %h want busy=1 %h", k, i, {Busy, HI, LO}, exp_vec());
        end
        tick(1'b0, 1'b0, NONE, 32'd0, 32'd0);
      end
      checks++;
      if ({Busy, HI, LO} !== {1'b0, ehi[k], elo[k]}) begin
        errors++;
        $display("FAIL div_result case=%0d: got busy=%b hi=%h lo=%h want 0/%h/%h", k, Busy, HI, LO, ehi[k], elo[k]);
      end
    end
  endtask

  task automatic test_mthi_mtlo();
    tick(1'b0, 1'b1, MTHI, 32'h12345678, 32'd0);
    checks++;
    if (Busy !== 1'b0 || HI !== 32'h12345678) begin
      errors++;
      $display("FAIL mthi: got busy=%b hi=%h want 0/12345678", Busy, HI);
    end
    tick(1'b0, 1'b1, MTLO, 32'h9ABCDEF0, 32'd0);
    checks++;
    if ({Busy, HI, LO} !== {1'b0, 32'h12345678, 32'h9ABCDEF0}) begin
      errors++;
      $display("FAIL mtlo: got busy=%b hi=%h lo=%h want 0/12345678/9abcdef0", Busy, HI, LO);
    end
    tick(1'b0, 1'b0, NONE, 32'd0, 32'd0);
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL mt_busy: got %b want 0", Busy);
    end
  endtask

  task automatic test_ignore_busy();
    tick(1'b0, 1'b1, DIV, 32'd100, 32'd7);
    tick(1'b0, 1'b1, MTLO, 32'd1, 32'd0);
    checks++;
    if (Busy !== 1'b1 || LO !== 32'h9ABCDEF0) begin
      errors++;
      $display("FAIL mtlo_in_busy: got busy=%b lo=%h want 1/9abcdef0", Busy, LO);
    end
    for (int i = 0; i < DC - 1; i++) tick(1'b0, 1'b0, NONE, 32'd0, 32'd0);
    checks++;
    if ({Busy, HI, LO} !== {1'b0, 32'd2, 32'd14}) begin
      errors++;
      $display("FAIL div_after_mtlo: got busy=%b hi=%h lo=%h want 0/00000002/0000000e", Busy, HI, LO);
    end
    tick(1'b0, 1'b1, DIV, 32'd5, 32'd0);
    checks++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("FAIL div0_busy: got %b want 1", Busy);
    end
    for (int i = 0; i < DC - 1; i++) tick(1'b0, 1'b0, NONE, 32'd0, 32'd0);
    checks++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("FAIL div0_last_busy: got %b want 1", Busy);
    end
    tick(1'b0, 1'b0, NONE, 32'd0, 32'd0);
    checks++;
    if ({Busy, HI, LO} !== {1'b0, 32'd2, 32'd14}) begin
      errors++;
      $display("FAIL div0_keep: got busy=%b hi=%h lo=%h want 0/00000002/0000000e", Busy, HI, LO);
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b0, 1'b1, MULT, 32'd1234, 32'd5);
    tick(1'b0, 1'b0, NONE, 32'd0, 32'd0);
    tick(1'b1, 1'b0, NONE, 32'd0, 32'd0);
    checks++;
    if ({Busy, HI, LO} !== {1'b0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b hi=%h lo=%h want 0/00000000/00000000", Busy, HI, LO);
    end
    tick(1'b0, 1'b1, MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checks++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_accept: got busy=%b want 1", Busy);
    end
    for (int i = 0; i < MC; i++) tick(1'b0, 1'b0, NONE, 32'd0, 32'd0);
    checks++;
    if ({Busy, HI, LO} !== {1'b0, 32'hFFFFFFFE, 32'd1}) begin
      errors++;
      $display("FAIL reset_mid_multu: got busy=%b hi=%h lo=%h want 0/fffffffe/00000001", Busy, HI, LO);
    end
  endtask

  task automatic test_back_to_back();
    tick(1'b0, 1'b1, MULT, 32'd6, 32'd7);
    for (int i = 0; i < MC - 1; i++) tick(1'b0, 1'b0, NONE, 32'd0, 32'd0);
    tick(1'b0, 1'b1, MULTU, 32'd2, 32'd3);
    checks++;
    if ({Busy, HI, LO} !== {1'b0, 32'd0, 32'd42}) begin
      errors++;
      $display("FAIL start_on_last: got busy=%b hi=%h lo=%h want 0/00000000/0000002a", Busy, HI, LO);
    end
    tick(1'b0, 1'b1, MULTU, 32'd2, 32'd3);
    checks++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("FAIL reissue_accept: got busy=%b want 1", Busy);
    end
    for (int i = 0; i < MC; i++) tick(1'b0, 1'b0, NONE, 32'd0, 32'd0);
    checks++;
    if ({Busy, HI, LO} !== {1'b0, 32'd0, 32'd6}) begin
      errors++;
      $display("FAIL reissue_result: got busy=%b hi=%h lo=%h want 0/00000000/00000006", Busy, HI, LO);
    end
  endtask

  task automatic test_random();
    logic        r, s;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 80) == 0);
      s  = ($urandom_range(0, 2) != 0);
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      tick(r, s, op, a, b);
      checks++;
      if ({Busy, HI, LO} !== exp_vec()) begin
        errors++;
        $display("FAIL random i=%0d op=%0d a=%h b=%h: got %h want %h", i, op, a, b, {Busy, HI, LO}, exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; MDOp = NONE; A = '0; B = '0;
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
